// File: rtl/bilateral_pkg.sv
// Shared widths, latency and default spatial kernel for the bilateral filter
// weight-accumulation stage.
package bilateral_pkg;

    localparam int DATA_W     = 8;
    localparam int WGT_W      = 10;
    localparam int LATENCY    = 12;
    localparam int NUM_W      = 22;
    localparam int DEN_W      = 14;
    localparam int TAPS       = 9;
    localparam int CENTRE_TAP = 4;
    localparam int DIV_STAGES = 8;

    // 3x3 Gaussian, sigma_s = 1.0, scaled so the centre tap is ~1.0 (0x3FF)
    localparam logic [WGT_W-1:0] DEF_SPA_C = 10'h3FF;
    localparam logic [WGT_W-1:0] DEF_SPA_E = 10'h26C;
    localparam logic [WGT_W-1:0] DEF_SPA_K = 10'h178;

    function automatic logic [WGT_W-1:0] spa_for_tap(
        input int               tap,
        input logic [WGT_W-1:0] spa_c,
        input logic [WGT_W-1:0] spa_e,
        input logic [WGT_W-1:0] spa_k
    );
        if (tap == CENTRE_TAP) begin
            return spa_c;
        end else if ((tap % 2) == 1) begin
            return spa_e;
        end else begin
            return spa_k;
        end
    endfunction

endpackage

// File: rtl/bilateral_div_stage.sv
// One restoring-division step: resolves quotient bit SHIFT by trial-subtracting
// den << SHIFT from the running remainder. Divisor and centre pixel ride along.
module bilateral_div_stage
    import bilateral_pkg::*;
#(
    parameter int SHIFT = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_W-1:0]  rem_in,
    input  logic [DEN_W-1:0]  den_in,
    input  logic [DATA_W-1:0] quo_in,
    input  logic [DATA_W-1:0] centre_in,
    output logic [NUM_W-1:0]  rem_out,
    output logic [DEN_W-1:0]  den_out,
    output logic [DATA_W-1:0] quo_out,
    output logic [DATA_W-1:0] centre_out
);

    logic [NUM_W-1:0]  divisor;
    logic [NUM_W-1:0]  rem_d,    rem_q;
    logic [DEN_W-1:0]  den_d,    den_q;
    logic [DATA_W-1:0] quo_d,    quo_q;
    logic [DATA_W-1:0] centre_d, centre_q;

    always_comb begin
        divisor  = NUM_W'(den_in) << SHIFT;
        rem_d    = rem_in;
        quo_d    = quo_in;
        den_d    = den_in;
        centre_d = centre_in;
        if (rem_in >= divisor) begin
            rem_d        = rem_in - divisor;
            quo_d[SHIFT] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            den_q    <= '0;
            quo_q    <= '0;
            centre_q <= '0;
        end else begin
            rem_q    <= rem_d;
            den_q    <= den_d;
            quo_q    <= quo_d;
            centre_q <= centre_d;
        end
    end

    assign rem_out    = rem_q;
    assign den_out    = den_q;
    assign quo_out    = quo_q;
    assign centre_out = centre_q;

endmodule

// File: rtl/bilateral_weight_accum.sv
// Bilateral filter accumulation: combines range and spatial weights, forms the
// weighted pixel sum and divides by the weight sum, one filtered pixel per clock.
module bilateral_weight_accum
    import bilateral_pkg::*;
#(
    parameter logic [WGT_W-1:0] SPA_C = DEF_SPA_C,
    parameter logic [WGT_W-1:0] SPA_E = DEF_SPA_E,
    parameter logic [WGT_W-1:0] SPA_K = DEF_SPA_K
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   per_frame_vsync,
    input  logic                   per_frame_href,
    input  logic                   per_frame_clken,
    input  logic [TAPS*DATA_W-1:0] per_img_win,
    input  logic [TAPS*WGT_W-1:0]  per_sim_wgt,
    output logic                   post_frame_vsync,
    output logic                   post_frame_href,
    output logic                   post_frame_clken,
    output logic [DATA_W-1:0]      post_img_Y
);

    localparam int PROD_W     = 2 * WGT_W;
    localparam int MUL_W      = WGT_W + DATA_W;
    localparam int PSUM_M_W   = MUL_W + 2;
    localparam int PSUM_W_W   = WGT_W + 2;
    localparam int GROUPS     = 3;
    // The sampling edge is itself a register rank, so LATENCY edges later
    // means LATENCY + 1 ranks in both the data path and the sync chain.
    localparam int PIPE_RANKS = LATENCY + 1;

    logic [WGT_W-1:0]    w1_d     [TAPS];
    logic [WGT_W-1:0]    w1_q     [TAPS];
    logic [DATA_W-1:0]   pix1_d   [TAPS];
    logic [DATA_W-1:0]   pix1_q   [TAPS];

    logic [MUL_W-1:0]    m2_d     [TAPS];
    logic [MUL_W-1:0]    m2_q     [TAPS];
    logic [WGT_W-1:0]    w2_q     [TAPS];
    logic [DATA_W-1:0]   centre2_q;

    logic [PSUM_M_W-1:0] msum3_d  [GROUPS];
    logic [PSUM_M_W-1:0] msum3_q  [GROUPS];
    logic [PSUM_W_W-1:0] wsum3_d  [GROUPS];
    logic [PSUM_W_W-1:0] wsum3_q  [GROUPS];
    logic [DATA_W-1:0]   centre3_q;

    logic [NUM_W-1:0]    num4;
    logic [NUM_W-1:0]    numr4_d, numr4_q;
    logic [DEN_W-1:0]    den4_d,  den4_q;
    logic [DATA_W-1:0]   centre4_q;

    logic [NUM_W-1:0]    rem_s    [DIV_STAGES+1];
    logic [DEN_W-1:0]    den_s    [DIV_STAGES+1];
    logic [DATA_W-1:0]   quo_s    [DIV_STAGES+1];
    logic [DATA_W-1:0]   centre_s [DIV_STAGES+1];

    logic [DATA_W-1:0]   y_d, y_q;
    logic [2:0]          sync_d   [PIPE_RANKS];
    logic [2:0]          sync_q   [PIPE_RANKS];

    // Combined weight keeps the upper 10 bits of the 20-bit range x spatial product
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            w1_d[i]   = WGT_W'((PROD_W'(per_sim_wgt[i*WGT_W +: WGT_W])
                              * PROD_W'(spa_for_tap(i, SPA_C, SPA_E, SPA_K))) >> WGT_W);
            pix1_d[i] = per_img_win[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                w1_q[i]   <= '0;
                pix1_q[i] <= '0;
            end
        end else begin
            w1_q   <= w1_d;
            pix1_q <= pix1_d;
        end
    end

    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            m2_d[i] = MUL_W'(w1_q[i]) * MUL_W'(pix1_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                m2_q[i] <= '0;
                w2_q[i] <= '0;
            end
            centre2_q <= '0;
        end else begin
            m2_q      <= m2_d;
            w2_q      <= w1_q;
            centre2_q <= pix1_q[CENTRE_TAP];
        end
    end

    // Row-wise partial sums keep each adder level to three operands
    always_comb begin
        for (int g = 0; g < GROUPS; g++) begin
            msum3_d[g] = PSUM_M_W'(m2_q[3*g]) + PSUM_M_W'(m2_q[3*g+1])
                       + PSUM_M_W'(m2_q[3*g+2]);
            wsum3_d[g] = PSUM_W_W'(w2_q[3*g]) + PSUM_W_W'(w2_q[3*g+1])
                       + PSUM_W_W'(w2_q[3*g+2]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < GROUPS; g++) begin
                msum3_q[g] <= '0;
                wsum3_q[g] <= '0;
            end
            centre3_q <= '0;
        end else begin
            msum3_q   <= msum3_d;
            wsum3_q   <= wsum3_d;
            centre3_q <= centre2_q;
        end
    end

    // Adding den/2 before the truncating divide rounds to nearest
    always_comb begin
        num4   = '0;
        den4_d = '0;
        for (int g = 0; g < GROUPS; g++) begin
            num4   = num4 + NUM_W'(msum3_q[g]);
            den4_d = den4_d + DEN_W'(wsum3_q[g]);
        end
        numr4_d = num4 + NUM_W'(den4_d >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            numr4_q   <= '0;
            den4_q    <= '0;
            centre4_q <= '0;
        end else begin
            numr4_q   <= numr4_d;
            den4_q    <= den4_d;
            centre4_q <= centre3_q;
        end
    end

    assign rem_s[0]    = numr4_q;
    assign den_s[0]    = den4_q;
    assign quo_s[0]    = '0;
    assign centre_s[0] = centre4_q;

    for (genvar k = 0; k < DIV_STAGES; k++) begin : g_div
        bilateral_div_stage #(
            .SHIFT(DIV_STAGES - 1 - k)
        ) u_div_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .rem_in    (rem_s[k]),
            .den_in    (den_s[k]),
            .quo_in    (quo_s[k]),
            .centre_in (centre_s[k]),
            .rem_out   (rem_s[k+1]),
            .den_out   (den_s[k+1]),
            .quo_out   (quo_s[k+1]),
            .centre_out(centre_s[k+1])
        );
    end

    // A final remainder still >= den means the true quotient needed a ninth
    // bit; the restoring steps have then already set every bit, but the
    // explicit clamp keeps the result correct regardless.
    always_comb begin
        y_d = quo_s[DIV_STAGES];
        if (den_s[DIV_STAGES] == '0) begin
            y_d = centre_s[DIV_STAGES];
        end else if (rem_s[DIV_STAGES] >= NUM_W'(den_s[DIV_STAGES])) begin
            y_d = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    always_comb begin
        sync_d[0] = {per_frame_vsync, per_frame_href, per_frame_clken};
        for (int r = 1; r < PIPE_RANKS; r++) begin
            sync_d[r] = sync_q[r-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < PIPE_RANKS; r++) begin
                sync_q[r] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign {post_frame_vsync, post_frame_href, post_frame_clken} = sync_q[PIPE_RANKS-1];
    assign post_img_Y = y_q;

endmodule

// File: tb/tb_bilateral_weight_accum.sv
// Scoreboard bench for bilateral_weight_accum: directed windows, a streamed
// 640-pixel line against a reference model, and a mid-line reset.
module tb_bilateral_weight_accum;

    localparam int LAT = 12;
    // Output for the window sampled at edge N is read on the negedge after N+12,
    // which is the 13th stimulus step after the one that drove it.
    localparam int SB_DEPTH = LAT + 1;

    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       ce;
        logic [7:0] y;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic [71:0] per_img_win;
    logic [89:0] per_sim_wgt;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic [7:0]  post_img_Y;

    exp_t        sb[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [71:0] rwin;
    logic [89:0] rsim;

    always #5 clk = ~clk;

    bilateral_weight_accum dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_href  (per_frame_href),
        .per_frame_clken (per_frame_clken),
        .per_img_win     (per_img_win),
        .per_sim_wgt     (per_sim_wgt),
        .post_frame_vsync(post_frame_vsync),
        .post_frame_href (post_frame_href),
        .post_frame_clken(post_frame_clken),
        .post_img_Y      (post_img_Y)
    );

    function automatic logic [7:0] refPixel(input logic [71:0] win, input logic [89:0] sim);
        int unsigned spa, w, num, den, q;
        num = 0;
        den = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 4)          spa = 32'h3FF;
            else if (i % 2 == 1) spa = 32'h26C;
            else                 spa = 32'h178;
            w   = (int'(sim[i*10 +: 10]) * spa) >> 10;
            num = num + w * int'(win[i*8 +: 8]);
            den = den + w;
        end
        if (den == 0) return win[39:32];
        q = (num + den / 2) / den;
        if (q > 255) q = 255;
        return q[7:0];
    endfunction

    function automatic logic [71:0] packWin(input logic [7:0] outer, input logic [7:0] centre);
        logic [71:0] v;
        for (int i = 0; i < 9; i++) v[i*8 +: 8] = (i == 4) ? centre : outer;
        return v;
    endfunction

    function automatic logic [89:0] packSim(input logic [9:0] outer, input logic [9:0] centre);
        logic [89:0] v;
        for (int i = 0; i < 9; i++) v[i*10 +: 10] = (i == 4) ? centre : outer;
        return v;
    endfunction

    task automatic randomWindow();
        for (int i = 0; i < 9; i++) begin
            rwin[i*8 +: 8]   = 8'($urandom_range(0, 255));
            rsim[i*10 +: 10] = (i == 4) ? 10'h3FF : 10'($urandom_range(0, 1023));
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL scoreboard_empty: observed 0 entries, required 1");
            return;
        end
        e = sb.pop_front();
        tests_run++;
        assert (post_frame_vsync === e.vs) else begin
            tests_failed++;
            $error("FAIL vsync: observed %b expected %b", post_frame_vsync, e.vs);
        end
        tests_run++;
        assert (post_frame_href === e.hs) else begin
            tests_failed++;
            $error("FAIL href: observed %b expected %b", post_frame_href, e.hs);
        end
        tests_run++;
        assert (post_frame_clken === e.ce) else begin
            tests_failed++;
            $error("FAIL clken: observed %b expected %b", post_frame_clken, e.ce);
        end
        if (e.ce) begin
            tests_run++;
            assert (post_img_Y === e.y) else begin
                tests_failed++;
                $error("FAIL pixel: observed %0d expected %0d", post_img_Y, e.y);
            end
        end
    endtask

    task automatic applyStimulus(input logic vs, input logic hs, input logic ce,
                                 input logic [71:0] win, input logic [89:0] sim,
                                 input logic [7:0] y_exp);
        @(negedge clk);
        checkOutput();
        per_frame_vsync = vs;
        per_frame_href  = hs;
        per_frame_clken = ce;
        per_img_win     = win;
        per_sim_wgt     = sim;
        sb.push_back('{vs, hs, ce, y_exp});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'd0);
    endtask

    task automatic checkResetZero(input string tag);
        tests_run++;
        assert ({post_frame_vsync, post_frame_href, post_frame_clken} === 3'b000) else begin
            tests_failed++;
            $error("FAIL %s_sync: observed %b expected 000", tag,
                   {post_frame_vsync, post_frame_href, post_frame_clken});
        end
        tests_run++;
        assert (post_img_Y === 8'd0) else begin
            tests_failed++;
            $error("FAIL %s_pixel: observed %0d expected 0", tag, post_img_Y);
        end
    endtask

    task automatic releaseReset();
        rst_n           = 1'b1;
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_win     = '0;
        per_sim_wgt     = '0;
        sb.delete();
        for (int i = 0; i < SB_DEPTH; i++) sb.push_back('{1'b0, 1'b0, 1'b0, 8'd0});
    endtask

    initial begin
        rst_n           = 1'b0;
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_win     = '0;
        per_sim_wgt     = '0;
        repeat (3) @(negedge clk);
        #1 checkResetZero("reset");
        releaseReset();

        applyStimulus(1'b0, 1'b0, 1'b1, packWin(8'd100, 8'd100), packSim(10'h3FF, 10'h3FF), 8'd100);
        idle(14);
        applyStimulus(1'b0, 1'b1, 1'b1, packWin(8'd0, 8'd200),   packSim(10'h000, 10'h3FF), 8'd200);
        applyStimulus(1'b0, 1'b1, 1'b1, packWin(8'd255, 8'd0),   packSim(10'h3FF, 10'h3FF), 8'd203);
        applyStimulus(1'b0, 1'b1, 1'b1, packWin(8'd50, 8'd77),   packSim(10'h000, 10'h000), 8'd77);
        idle(14);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 8'd0);
        idle(4);
        for (int i = 0; i < 640; i++) begin
            randomWindow();
            applyStimulus(1'b0, 1'b1, 1'b1, rwin, rsim, refPixel(rwin, rsim));
        end
        idle(14);

        for (int i = 0; i < 20; i++) begin
            randomWindow();
            applyStimulus(1'b0, 1'b1, 1'b1, rwin, rsim, refPixel(rwin, rsim));
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1 checkResetZero("async_reset");
        repeat (3) @(negedge clk);
        checkResetZero("reset_hold");
        releaseReset();
        idle(3);
        for (int i = 0; i < 4; i++) begin
            randomWindow();
            applyStimulus(1'b0, 1'b1, 1'b1, rwin, rsim, refPixel(rwin, rsim));
        end
        idle(14);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bilateral_weight_accum.md
Name: bilateral_weight_accum

Overview:
- Downstream stage of the bilateral filter's similarity-weight lookup.
- Consumes one 3x3 window per clock: nine 8-bit pixels plus the nine 10-bit range (similarity) weights already looked up for |p_i - p_centre|.
- Multiplies each range weight by a fixed 3x3 spatial Gaussian weight, forms the normalised weighted average and emits the filtered 8-bit pixel.
- Fully pipelined, one pixel per clock; frame sync signals are delayed to match the data latency.

Parameters:
- DATA_W, 8, pixel width.
- WGT_W, 10, range/spatial weight width (unsigned fixed-point, 0x3FF ≈ 1.0).
- SPA_C, 10'h3FF, spatial weight for the centre tap.
- SPA_E, 10'h26C, spatial weight for the 4 edge taps (sigma_s = 1.0).
- SPA_K, 10'h178, spatial weight for the 4 corner taps.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- per_frame_vsync  in  1  input vsync.
- per_frame_href  in  1  input href.
- per_frame_clken  in  1  input pixel valid.
- per_img_win  in  72  window pixels p0..p8, row-major; p0 = [7:0]; p4 is the centre.
- per_sim_wgt  in  90  range weights s0..s8; s0 = [9:0]; s4 is expected to be 0x3FF.
- post_frame_vsync  out  1  vsync delayed by LATENCY.
- post_frame_href  out  1  href delayed by LATENCY.
- post_frame_clken  out  1  clken delayed by LATENCY.
- post_img_Y  out  8  filtered pixel.

Behaviour:
- Reset (rst_n low, asynchronous): every pipeline register and every output is 0. Reset mid-frame flushes the pipeline completely; after release, outputs are 0 until new inputs propagate.
- The pipeline is free-running and computes every cycle. Data is meaningful only where post_frame_clken = 1.
- LATENCY = 12 clocks, fixed (localparam). An input sampled on edge N appears at the outputs after edge N+12.
- Sync signals pass through a 12-deep shift register in lockstep with the data, so vsync, href and clken keep their mutual alignment.
- S1: w_i = (s_i * spa_i) >> 10.
  - 20-bit product truncated to 10 bits.
  - spa_i = SPA_C for i = 4; SPA_E for i = 1, 3, 5, 7; SPA_K otherwise.
  - Pixels and the centre pixel are registered alongside.
- S2: m_i = w_i * p_i (18 bits); w_i registered.
- S3: three partial sums of three taps each, for both m and w.
- S4: num = sum m_i (22 bits); den = sum w_i (14 bits); numr = num + (den >> 1) (22 bits, no overflow since numr < 2^22).
- S5..S12: restoring divider, one quotient bit per stage, MSB first.
  - Stage k (k = 0..7) compares the remainder against den << (7-k).
  - Stage k subtracts when the remainder is ≥ that value and sets quotient bit 7-k.
  - den and the centre pixel travel with the divider.
- Output: post_img_Y = quotient, i.e. floor((num + den/2) / den), rounded to nearest.
  - Saturate to 255 if the quotient would exceed 8 bits. This is mathematically unreachable, but the saturation logic is still required.
- den == 0 (all range weights zero): post_img_Y = centre pixel p4 of that window. No X propagation and no divide fault.
- Consecutive windows are fully independent; back-to-back clken = 1 yields back-to-back outputs with no bubbles.

Decomposition:
- Package bilateral_pkg holds:
  - DATA_W, WGT_W, LATENCY = 12.
  - Default spatial weight constants SPA_C / SPA_E / SPA_K.
  - Derived widths: NUM_W = 22, DEN_W = 14.
- Sub-module bilateral_div_stage: one restoring-divider step (remainder in, den, quotient-so-far in, registered outputs). It is instantiated 8 times via generate.
- The top module holds the weight multiply, the adder tree and the sync delay.

Test Plan:
- Flat window: all p_i = 100, all s_i = 0x3FF, one clken pulse → post_frame_clken high exactly 12 clocks later with post_img_Y = 100.
- Isolated centre: p4 = 200, other p_i = 0, s4 = 0x3FF, other s_i = 0 → post_img_Y = 200.
- Edge step: p4 = 0, all other p_i = 255, all s_i = 0x3FF → den = 4998, num = 1013880, post_img_Y = 203.
- Zero denominator: all s_i = 0, p4 = 77 → post_img_Y = 77.
- Streaming: 640-pixel href line with clken every cycle and random windows → outputs match the reference model pixel-for-pixel; vsync/href/clken are delayed by exactly 12 and keep their mutual alignment.
- Reset mid-line: assert rst_n low for 3 clocks while clken = 1 → all outputs 0 immediately (asynchronously); after release, post_frame_clken stays 0 until 12 clocks after the first new clken.
